// File: rtl/cfg_stream_if.sv
// Valid/ready word stream feeding the configuration loader.
// The source drives data and valid. The loader drives ready.
interface cfg_stream_if #(
  parameter int WORD_W = 8
) ();
  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/cfg_stream_loader.sv
// Serialises configuration words LSB-first onto bit_out for a chain of targets.
// It also drives the active-low programming window and a one-hot per-target shift strobe.
module cfg_stream_loader #(
  parameter int                       NUM_TGT   = 3,
  parameter int                       LEN_W     = 16,
  parameter logic [NUM_TGT*LEN_W-1:0] TGT_LEN   = {16'd104, 16'd384, 16'd296},
  parameter int                       WORD_W    = 8,
  parameter int                       FLUSH_CYC = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  cfg_stream_if.slave        cfg,
  output logic               bit_out,
  output logic [NUM_TGT-1:0] tgt_en,
  output logic               prgm_b,
  output logic               busy,
  output logic               done,
  output logic               err
);

  function automatic int max_len();
    int m;
    m = 1;
    for (int i = 0; i < NUM_TGT; i++)
      if (int'(TGT_LEN[i*LEN_W +: LEN_W]) > m) m = int'(TGT_LEN[i*LEN_W +: LEN_W]);
    return m;
  endfunction

  localparam int MAX_LEN    = max_len();
  localparam int BIT_W      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TGT_W      = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;
  localparam int BCNT_W     = $clog2(WORD_W + 1);
  localparam int FC_W       = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam int FLUSH_LAST = (FLUSH_CYC > 0) ? FLUSH_CYC - 1 : 0;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  function automatic logic [NUM_TGT-1:0] onehot(input logic [TGT_W-1:0] idx);
    return NUM_TGT'(1) << idx;
  endfunction

  state_t              state;
  logic [WORD_W-1:0]   word_q;
  logic [BCNT_W-1:0]   buf_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [TGT_W-1:0]    tgt_idx;
  logic [FC_W-1:0]     flush_cnt;

  logic                shift;
  logic                tgt_last_bit;
  logic                final_bit;
  logic                accept;
  logic [LEN_W-1:0]    cur_len;

  assign cur_len      = TGT_LEN[int'(tgt_idx)*LEN_W +: LEN_W];
  assign shift        = (state == LOAD) && (buf_cnt != '0) && !abort;
  assign tgt_last_bit = (LEN_W'(bit_cnt) == cur_len - 1'b1);
  assign final_bit    = shift && tgt_last_bit && (tgt_idx == TGT_W'(NUM_TGT - 1));

  // Refill on the same edge the last buffered bit leaves, so the stream has no bubble.
  assign cfg.in_ready = (state == LOAD) && !abort && !final_bit &&
                        ((buf_cnt == '0) || ((buf_cnt == BCNT_W'(1)) && shift));
  assign accept       = cfg.in_valid && cfg.in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      word_q    <= '0;
      buf_cnt   <= '0;
      bit_cnt   <= '0;
      tgt_idx   <= '0;
      flush_cnt <= '0;
      bit_out   <= 1'b0;
      tgt_en    <= '0;
      prgm_b    <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && (state == LOAD || state == FLUSH)) begin
        // Abort beats any shift or target advance on this edge.
        state   <= IDLE;
        word_q  <= '0;
        buf_cnt <= '0;
        bit_cnt <= '0;
        tgt_idx <= '0;
        tgt_en  <= '0;
        prgm_b  <= 1'b1;
        busy    <= 1'b0;
        err     <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            tgt_en <= '0;
            if (start && !abort) begin
              state   <= LOAD;
              prgm_b  <= 1'b0;
              busy    <= 1'b1;
              err     <= 1'b0;
              word_q  <= '0;
              buf_cnt <= '0;
              bit_cnt <= '0;
              tgt_idx <= '0;
            end
          end
          LOAD: begin
            if (shift) begin
              bit_out <= word_q[0];
              tgt_en  <= onehot(tgt_idx);
              word_q  <= word_q >> 1;
              buf_cnt <= buf_cnt - 1'b1;
              if (tgt_last_bit) begin
                bit_cnt <= '0;
                tgt_idx <= tgt_idx + 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              tgt_en <= '0;
            end
            if (accept) begin
              word_q  <= cfg.in_data;
              buf_cnt <= BCNT_W'(WORD_W);
            end
            // Whatever is still buffered after the final bit is dropped.
            if (final_bit) begin
              word_q    <= '0;
              buf_cnt   <= '0;
              bit_cnt   <= '0;
              tgt_idx   <= '0;
              flush_cnt <= '0;
              if (FLUSH_CYC == 0) begin
                state  <= DONE;
                prgm_b <= 1'b1;
                busy   <= 1'b0;
                done   <= 1'b1;
              end else begin
                state <= FLUSH;
              end
            end
          end
          FLUSH: begin
            tgt_en <= '0;
            if (flush_cnt == FC_W'(FLUSH_LAST)) begin
              state  <= DONE;
              prgm_b <= 1'b1;
              busy   <= 1'b0;
              done   <= 1'b1;
            end else begin
              flush_cnt <= flush_cnt + 1'b1;
            end
          end
          DONE: begin
            tgt_en <= '0;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cfg_stream_loader.sv
// Randomised and directed bench for cfg_stream_loader.
// A small two-target instance is checked against a bit-stream model. A default instance covers the full-length load.
`timescale 1ns/1ps
module tb_cfg_stream_loader;

  localparam int S_WW  = 4;
  localparam int S_FC  = 2;
  localparam int S_TOT = 8;
  localparam logic [31:0] S_LEN = {16'd3, 16'd5};
  localparam int D_FC  = 2;

  int s_len [2] = '{5, 3};
  int d_len [3] = '{296, 384, 104};

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic start_d = 1'b0;
  always #5 clk = ~clk;

  cfg_stream_if #(.WORD_W(4)) s_if ();
  cfg_stream_if #(.WORD_W(8)) d_if ();

  logic       bit_out, prgm_b, busy, done, err;
  logic [1:0] tgt_en;
  logic       bit_out_d, prgm_b_d, busy_d, done_d, err_d;
  logic [2:0] tgt_en_d;

  cfg_stream_loader #(.NUM_TGT(2), .LEN_W(16), .TGT_LEN(S_LEN), .WORD_W(4), .FLUSH_CYC(S_FC)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .cfg(s_if),
    .bit_out(bit_out), .tgt_en(tgt_en), .prgm_b(prgm_b), .busy(busy), .done(done), .err(err));

  cfg_stream_loader dut_d (
    .clk(clk), .reset(reset), .start(start_d), .abort(1'b0), .cfg(d_if),
    .bit_out(bit_out_d), .tgt_en(tgt_en_d), .prgm_b(prgm_b_d), .busy(busy_d), .done(done_d), .err(err_d));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int       wr_idx;
  bit       acc;
  logic [3:0] words [4];
  int       got_tgt [$];
  bit       got_bit [$];
  int       done_cnt, done_cyc, last_cyc, first_cyc, acc_cyc, gaps, prgm_bad, onehot_bad;
  bit       last_aborted = 1'b0;

  bit d_mon = 1'b0;
  int d_cnt [3];
  int d_gaps, d_last, d_prev_idx, d_order_bad, d_prgm_lo, d_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_mon();
    wr_idx = 0; done_cnt = 0; done_cyc = -1; last_cyc = -1; first_cyc = -1;
    acc_cyc = -1; gaps = 0; prgm_bad = 0; onehot_bad = 0;
    got_tgt.delete(); got_bit.delete();
  endtask

  task automatic observe();
    int idx;
    if (tgt_en != 2'b00) begin
      if (tgt_en == 2'b11) onehot_bad++;
      got_tgt.push_back(tgt_en[1] ? 1 : 0);
      got_bit.push_back(bit_out);
      if (first_cyc < 0) first_cyc = cyc;
      else gaps += cyc - last_cyc - 1;
      last_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      if (!prgm_b) prgm_bad++;
    end
    if (busy && prgm_b) prgm_bad++;
    if (d_mon) begin
      if (tgt_en_d != 3'b000) begin
        idx = tgt_en_d[2] ? 2 : (tgt_en_d[1] ? 1 : 0);
        if (idx < d_prev_idx) d_order_bad++;
        d_prev_idx = idx;
        d_cnt[idx]++;
        if (d_last >= 0) d_gaps += cyc - d_last - 1;
        d_last = cyc;
      end
      if (!prgm_b_d) d_prgm_lo++;
      if (done_d) d_done++;
    end
  endtask

  // Inputs are already driven for this window; advance through one rising edge.
  task automatic cycle();
    #1;
    acc = s_if.in_valid && s_if.in_ready;
    @(negedge clk);
    cyc++;
    if (acc) begin
      if (wr_idx == 0) acc_cyc = cyc;
      wr_idx++;
    end
    observe();
  endtask

  task automatic run_load(input int vpct, input int hold, input int abort_after,
                          input int start_mid_at, input bit rnd, output int gaps_out);
    logic [31:0] eb, et, gb, gt;
    logic [3:0]  w;
    int          hold_left;
    bit          aborted;
    hold_left = hold;
    aborted   = 1'b0;
    gaps_out  = -1;
    if (rnd) for (int i = 0; i < 4; i++) words[i] = 4'($urandom);
    clear_mon();
    if (last_aborted) chk("err_sticky", err, 1);
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("start_prgm", prgm_b, 0);
    chk("start_busy", busy, 1);
    chk("start_err", err, 0);
    for (int lim = 0; lim < 200 && done_cnt == 0 && !aborted; lim++) begin
      s_if.in_data = words[(wr_idx < 4) ? wr_idx : 3];
      if (wr_idx == 1 && hold_left > 0) begin
        s_if.in_valid = 1'b0;
        hold_left--;
      end else begin
        s_if.in_valid = ($urandom_range(99) < vpct);
      end
      abort = (abort_after >= 0) && (got_tgt.size() == abort_after);
      start = (start_mid_at >= 0) && (got_tgt.size() == start_mid_at);
      cycle();
      if (abort) begin
        aborted = 1'b1;
        abort = 1'b0;
        start = 1'b0;
        chk("abort_prgm", prgm_b, 1);
        chk("abort_tgt_en", tgt_en, 0);
        chk("abort_err", err, 1);
        chk("abort_busy", busy, 0);
      end
    end
    start = 1'b0;
    s_if.in_valid = 1'b0;
    if (aborted) begin
      cycle();
      cycle();
      chk("abort_nodone", done_cnt, 0);
      last_aborted = 1'b1;
    end else begin
      chk("done_seen", done_cnt, 1);
      cycle();
      cycle();
      chk("done_once", done_cnt, 1);
      chk("words_taken", wr_idx, 2);
      chk("nbits", got_tgt.size(), S_TOT);
      eb = '0; et = '0; gb = '0; gt = '0;
      for (int p = 0; p < S_TOT; p++) begin
        w = words[p / S_WW];
        eb[p] = w[p % S_WW];
        et[p] = (p >= s_len[0]);
      end
      for (int i = 0; i < got_tgt.size() && i < 32; i++) begin
        gb[i] = got_bit[i];
        gt[i] = (got_tgt[i] != 0);
      end
      chk("bits", gb, eb);
      chk("tgts", gt, et);
      chk("first_lat", first_cyc - acc_cyc, 1);
      chk("flush_len", done_cyc - last_cyc, S_FC);
      chk("prgm_window", prgm_bad, 0);
      chk("onehot", onehot_bad, 0);
      chk("err_clear", err, 0);
      gaps_out = gaps;
      last_aborted = 1'b0;
    end
  endtask

  initial begin
    int g;
    int vp, ab, sm;
    s_if.in_valid = 1'b0;
    s_if.in_data  = '0;
    d_if.in_valid = 1'b1;
    d_if.in_data  = 8'hFF;
    clear_mon();

    @(negedge clk);
    @(negedge clk);
    chk("rst_prgm", prgm_b, 1);
    chk("rst_tgt_en", tgt_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", s_if.in_ready, 0);
    chk("rst_bit", bit_out, 0);
    reset = 1'b1;
    @(negedge clk);

    // Directed: two back-to-back words, no stalls.
    words[0] = 4'b1011; words[1] = 4'b0110; words[2] = 4'b0000; words[3] = 4'b0000;
    run_load(100, 0, -1, -1, 1'b0, g);
    chk("t1_gaps", g, 0);

    // Valid low for 6 windows after word 0: 3 are covered by the buffered bits, 3 stall the line.
    run_load(100, 6, -1, -1, 1'b0, g);
    chk("t2_gaps", g, 3);

    // Abort in the middle of target 1, then a clean reload.
    run_load(100, 0, 6, -1, 1'b1, g);
    run_load(100, 0, -1, 3, 1'b1, g);

    // start together with abort in IDLE must not launch a load.
    clear_mon();
    start = 1'b1;
    abort = 1'b1;
    cycle();
    start = 1'b0;
    abort = 1'b0;
    chk("idle_sa_busy", busy, 0);
    chk("idle_sa_prgm", prgm_b, 1);
    cycle();
    cycle();
    chk("idle_sa_strobes", got_tgt.size(), 0);

    // Full default chain with an always-valid all-ones source.
    d_mon = 1'b1;
    d_cnt = '{0, 0, 0};
    d_gaps = 0; d_last = -1; d_prev_idx = 0; d_order_bad = 0; d_prgm_lo = 0; d_done = 0;
    start_d = 1'b1;
    cycle();
    start_d = 1'b0;
    for (int lim = 0; lim < 1200 && d_done == 0; lim++) cycle();
    cycle();
    d_mon = 1'b0;
    chk("d_tgt0", d_cnt[0], d_len[0]);
    chk("d_tgt1", d_cnt[1], d_len[1]);
    chk("d_tgt2", d_cnt[2], d_len[2]);
    chk("d_gaps", d_gaps, 0);
    chk("d_order", d_order_bad, 0);
    chk("d_done", d_done, 1);
    // One intake cycle before the first word lands, then every bit, then the flush.
    chk("d_prgm_low", d_prgm_lo, 1 + d_len[0] + d_len[1] + d_len[2] + D_FC);

    // Leave err set, then hit reset in the middle of a load.
    run_load(100, 0, 2, -1, 1'b1, g);
    clear_mon();
    start = 1'b1;
    cycle();
    start = 1'b0;
    s_if.in_valid = 1'b1;
    s_if.in_data  = 4'hF;
    cycle();
    cycle();
    cycle();
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_bit", bit_out, 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_prgm", prgm_b, 1);
    chk("arst_tgt_en", tgt_en, 0);
    chk("arst_busy", busy, 0);
    chk("arst_err", err, 0);
    chk("arst_bit", bit_out, 0);
    chk("arst_ready", s_if.in_ready, 0);
    s_if.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    last_aborted = 1'b0;
    @(negedge clk);
    run_load(100, 0, -1, -1, 1'b1, g);
    chk("post_rst_gaps", g, 0);

    for (int n = 0; n < 20; n++) begin
      vp = int'($urandom_range(100, 40));
      ab = ($urandom_range(3) == 0) ? int'($urandom_range(8, 0)) : -1;
      sm = ($urandom_range(1) == 1) ? int'($urandom_range(7, 1)) : -1;
      run_load(vp, 0, ab, sm, 1'b1, g);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
